// File: rtl/uart_pkg.sv
// Shared UART definitions: baud tick default, parity modes and transmitter FSM states.
// Receiver and transmitter both import this so they agree on one baud definition.
package uart_pkg;

  localparam int DEFAULT_TICKS_PER_BIT = 20;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit timer: counts 0..TICKS_PER_BIT-1 and flags the last tick of each bit.
// restart holds the count at zero so a bit starts cleanly on the next cycle.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = DEFAULT_TICKS_PER_BIT
) (
  input  logic clk_br,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int CNT_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_BIT - 1);

  logic [CNT_W-1:0] tick_reg;

  always_ff @(posedge clk_br) begin
    if (rst || restart || bit_end) begin
      tick_reg <= '0;
    end else begin
      tick_reg <= tick_reg + 1'b1;
    end
  end

  assign bit_end = (tick_reg == LAST_TICK);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte in, start + LSB-first data + optional parity + stop bits out.
// tx is registered from the next-state decode so the start bit appears on the accepting edge.
module uart_tx
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = DEFAULT_TICKS_PER_BIT,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = PAR_NONE,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk_br,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_t            state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 tx_reg, tx_next;
  logic                 bit_end;
  logic                 accept;
  logic                 last_data_bit;
  logic                 last_stop_bit;

  uart_bit_timer #(
    .TICKS_PER_BIT(TICKS_PER_BIT)
  ) u_bit_timer (
    .clk_br (clk_br),
    .rst    (rst),
    .restart(state_reg == ST_IDLE),
    .bit_end(bit_end)
  );

  assign last_data_bit = bit_end && (idx_reg == LAST_DATA);
  assign last_stop_bit = bit_end && (idx_reg == LAST_STOP);

  // Ready in the final stop cycle lets the next frame start with no idle gap.
  assign tx_ready = !rst && ((state_reg == ST_IDLE) ||
                             ((state_reg == ST_STOP) && last_stop_bit));
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state_reg != ST_IDLE);
  assign tx       = tx_reg;

  always_ff @(posedge clk_br) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = ST_START;
      ST_START:  if (bit_end) state_next = ST_DATA;
      ST_DATA:   if (last_data_bit) state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_next = ST_STOP;
      ST_STOP:   if (last_stop_bit) state_next = accept ? ST_START : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_next  = shift_reg;
    parity_next = parity_reg;
    idx_next    = idx_reg;
    tx_next     = 1'b1;

    if (accept) begin
      shift_next  = tx_data;
      parity_next = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
    end else if ((state_reg == ST_DATA) && bit_end) begin
      shift_next = shift_reg >> 1;
    end

    // One index counter serves both the data bits and the stop bits; it wraps to 0 at each phase end.
    if (bit_end && (state_reg == ST_DATA)) begin
      idx_next = last_data_bit ? '0 : idx_reg + 1'b1;
    end else if (bit_end && (state_reg == ST_STOP)) begin
      idx_next = last_stop_bit ? '0 : idx_reg + 1'b1;
    end

    case (state_next)
      ST_IDLE:   tx_next = 1'b1;
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = parity_next;
      ST_STOP:   tx_next = 1'b1;
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_br) begin
    if (rst) begin
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      idx_reg    <= '0;
      tx_reg     <= 1'b1;
    end else begin
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      idx_reg    <= idx_next;
      tx_reg     <= tx_next;
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, the transmit-side counterpart of the team's oversampled UART receiver.
- Accepts a parallel byte over a valid/ready handshake and serialises it onto `tx`: start bit, LSB-first data, optional parity, stop bit(s).
- Runs on the same oversampled baud clock `clk_br` as the receiver; one bit lasts TICKS_PER_BIT clocks (receiver convention: 20).

Parameters:
TICKS_PER_BIT, 20, clk_br cycles per serial bit (>=2)
DATA_BITS, 8, data bits per frame (5..8)
PARITY, 0, 0=none, 1=even, 2=odd
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk_br  input  1  oversampled baud clock; the only clock
rst  input  1  synchronous, active-high reset
tx_data  input  DATA_BITS  byte to send; sampled only on acceptance
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a byte this cycle
tx  output  1  serial line, idle high
busy  output  1  frame in progress (START..STOP)

Behaviour:
- Interface: one clock (`clk_br`); reset is synchronous and active-high.
- Reset values: tx=1, busy=0, tx_ready=0 while rst=1, state=IDLE, all counters 0.
- Reset mid-frame: frame abandoned; tx=1 on the first clock edge with rst=1; no residual bits are sent after release.
- Acceptance: a transfer occurs on a rising edge with tx_valid=1 and tx_ready=1.
  - tx_data is captured into the shift register.
  - Parity is computed from the captured data.
- tx_ready is high in IDLE, and during the final clk_br cycle of the last stop bit. This allows back-to-back frames with no idle gap. It is low otherwise.
- tx_valid while tx_ready=0 is ignored; no data is captured.
- tx_data changes after acceptance have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. On acceptance -> START.
  - START: tx=0 for TICKS_PER_BIT cycles, then -> DATA.
  - DATA: tx = shift_reg[0]; shift right at each bit end. After DATA_BITS bits -> PARITY if PARITY!=0, else -> STOP.
  - PARITY: tx = even ? ^data : ~^data, for one bit time, then -> STOP.
  - STOP: tx=1 for STOP_BITS*TICKS_PER_BIT cycles. Then -> START if accepted in the last cycle, else -> IDLE.
- Latency: tx falls on the clock edge that accepts the byte; the first start-bit cycle is that edge.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * TICKS_PER_BIT cycles exactly.
- Bit timer: tick counter runs 0..TICKS_PER_BIT-1 and wraps; a bit ends when the counter reads TICKS_PER_BIT-1.
- Bit index counter: counts 0..DATA_BITS-1 in DATA; counts 0..STOP_BITS-1 in STOP.
- Counter widths are $clog2 of their maximum + 1; no overflow is possible.
- busy: 1 in START/DATA/PARITY/STOP, 0 in IDLE. It stays 1 across back-to-back frames.
- tx is driven from a register (glitch-free), never combinationally from the state.

Decomposition:
- Package uart_pkg holds:
  - FSM state typedef (IDLE, START, DATA, PARITY, STOP);
  - parity constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - default TICKS_PER_BIT = 20, so the receiver and transmitter share one baud definition.
- Sub-module uart_bit_timer (parameter TICKS_PER_BIT):
  - inputs clk_br, rst, restart;
  - output bit_end;
  - reused later by the receiver rewrite.

Test Plan:
- Reset, then idle 100 cycles -> tx=1, busy=0, tx_ready=1 throughout.
- Send 0x55, PARITY=0, TICKS_PER_BIT=20 -> tx is:
  - low cycles 0-19 (start);
  - then bits 1,0,1,0,1,0,1,0, 20 cycles each;
  - high cycles 180-199 (stop).
  - busy falls at cycle 200; tx_ready is high at cycle 199.
- Back-to-back 0xA3 then 0x0F, tx_valid held high -> second start bit begins at cycle 200 with no idle gap. Receiver model decodes 0xA3, 0x0F.
- PARITY=1 with 0x07, then PARITY=2 with 0x07 -> parity bit (cycles 180-199) is 1 for even, 0 for odd. Frame is 220 cycles.
- rst asserted at cycle 90 of a frame for 1 cycle -> tx=1 from the next edge, busy=0, no further low bits. A new byte accepted afterwards is sent intact.
- tx_valid pulsed while busy (mid DATA), with tx_data changing throughout -> pulse ignored; transmitted byte equals the originally accepted value.
